// File: rtl/icache_intc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_intc_pkg
// Description : Shared types and helpers for the icache interconnect routing.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_intc_pkg;

    localparam int c_DEFAULT_BANKS = 16;
    localparam int c_DEFAULT_UID_W = 8;

    typedef logic [$clog2(c_DEFAULT_BANKS)-1:0] bank_idx_t;
    typedef logic [c_DEFAULT_UID_W-1:0]         uid_t;

    // Width needed to hold a count in the range 0..depth inclusive.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic logic [63:0] onehot_from_index(input logic [31:0] idx);
        logic [63:0] r;
        r = '0;
        if (idx < 32'd64) begin
            r[idx[5:0]] = 1'b1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_intc_dest_fifo.sv
`default_nettype none
// ============================================================================
// Module      : icache_intc_dest_fifo
// Description : In-order FIFO of bank indices for outstanding fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_intc_dest_fifo
    import icache_intc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [WIDTH-1:0]              data_i,
    output logic [WIDTH-1:0]              data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [count_width(DEPTH)-1:0] count_o
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [WIDTH-1:0]   w_mem_d [DEPTH];
    logic [c_PTR_W-1:0] r_wptr_q, w_wptr_d;
    logic [c_PTR_W-1:0] r_rptr_q, w_rptr_d;
    logic [c_CNT_W-1:0] r_count_q, w_count_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign full_o    = (r_count_q == c_CNT_W'(DEPTH));
    assign empty_o   = (r_count_q == '0);
    assign count_o   = r_count_q;
    assign data_o    = r_mem_q[r_rptr_q];
    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;

    always_comb begin
        w_mem_d   = r_mem_q;
        w_wptr_d  = r_wptr_q;
        w_rptr_d  = r_rptr_q;
        w_count_d = r_count_q;
        if (w_do_push) begin
            w_mem_d[r_wptr_q] = data_i;
            w_wptr_d = (r_wptr_q == c_PTR_W'(DEPTH - 1)) ? '0 : r_wptr_q + c_PTR_W'(1);
        end
        if (w_do_pop) begin
            w_rptr_d = (r_rptr_q == c_PTR_W'(DEPTH - 1)) ? '0 : r_rptr_q + c_PTR_W'(1);
        end
        // Simultaneous push and pop leaves the count unchanged.
        if (w_do_push && !w_do_pop) begin
            w_count_d = r_count_q + c_CNT_W'(1);
        end else if (w_do_pop && !w_do_push) begin
            w_count_d = r_count_q - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_mem_q   <= w_mem_d;
            r_wptr_q  <= w_wptr_d;
            r_rptr_q  <= w_rptr_d;
            r_count_q <= w_count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/icache_intc_routing_block_pipe.sv
`default_nettype none
// ============================================================================
// Module      : icache_intc_routing_block_pipe
// Description : Per-fetch-port bank decode with in-order response return.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_intc_routing_block_pipe
    import icache_intc_pkg::*;
#(
    parameter int N_CACHE_BANKS   = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int DEST_WIDTH      = $clog2(N_CACHE_BANKS),
    parameter int UID_WIDTH       = 8,
    parameter int UID             = 1,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RESP_REG        = 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    request_i,
    input  logic [DEST_WIDTH-1:0]                   destination_i,
    output logic                                    grant_o,
    output logic [N_CACHE_BANKS-1:0]                request_o,
    input  logic [N_CACHE_BANKS-1:0]                grant_i,
    output logic [UID_WIDTH-1:0]                    UID_o,
    input  logic [N_CACHE_BANKS-1:0]                response_i,
    input  logic [N_CACHE_BANKS-1:0][DATA_WIDTH-1:0] read_data_i,
    output logic                                    response_o,
    output logic [DATA_WIDTH-1:0]                   read_data_o,
    output logic [count_width(MAX_OUTSTANDING)-1:0] outstanding_o,
    output logic                                    stray_resp_o
);

    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_hit;
    logic                     w_stray_d;
    logic                     r_stray_q;
    logic [DEST_WIDTH-1:0]    w_head;
    logic [N_CACHE_BANKS-1:0] w_dest_onehot;
    logic [N_CACHE_BANKS-1:0] w_head_onehot;
    logic [DATA_WIDTH-1:0]    w_head_data;

    assign UID_o = UID_WIDTH'(UID);

    // No full-bypass: a same-cycle pop does not reopen a full FIFO.
    assign w_dest_onehot = N_CACHE_BANKS'(onehot_from_index(32'(destination_i)));
    assign request_o     = (request_i & ~w_full) ? w_dest_onehot : '0;
    assign grant_o       = (|(grant_i & w_dest_onehot)) & ~w_full;
    assign w_push        = request_i & grant_o;

    assign w_head_onehot = w_empty ? '0 : N_CACHE_BANKS'(onehot_from_index(32'(w_head)));
    assign w_hit         = |(response_i & w_head_onehot);
    assign w_stray_d     = |(response_i & ~w_head_onehot);

    always_comb begin
        w_head_data = '0;
        for (int i = 0; i < N_CACHE_BANKS; i++) begin
            w_head_data = w_head_data | (read_data_i[i] & {DATA_WIDTH{w_head_onehot[i]}});
        end
    end

    icache_intc_dest_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (DEST_WIDTH)
    ) u_dest_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .pop_i   (w_hit),
        .data_i  (destination_i),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (outstanding_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stray_q <= 1'b0;
        end else begin
            r_stray_q <= w_stray_d;
        end
    end
    assign stray_resp_o = r_stray_q;

    generate
        if (RESP_REG != 0) begin : g_resp_reg
            logic                  r_response_q;
            logic [DATA_WIDTH-1:0] r_read_data_q, w_read_data_d;

            assign w_read_data_d = w_hit ? w_head_data : r_read_data_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_response_q  <= 1'b0;
                    r_read_data_q <= '0;
                end else begin
                    r_response_q  <= w_hit;
                    r_read_data_q <= w_read_data_d;
                end
            end
            assign response_o  = r_response_q;
            assign read_data_o = r_read_data_q;
        end else begin : g_resp_comb
            assign response_o  = w_hit;
            assign read_data_o = w_head_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_icache_intc_routing_block_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_intc_routing_block_pipe
// Description : Directed self-checking bench for the fetch routing block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_intc_routing_block_pipe;

    logic                  clk;
    logic                  rst_ni;
    logic                  request_i;
    logic [3:0]            destination_i;
    logic                  grant_o;
    logic [15:0]           request_o;
    logic [15:0]           grant_i;
    logic [7:0]            uid_o;
    logic [15:0]           response_i;
    logic [15:0][31:0]     read_data_i;
    logic                  response_o;
    logic [31:0]           read_data_o;
    logic [2:0]            outstanding_o;
    logic                  stray_resp_o;

    int checks;
    int failures;

    icache_intc_routing_block_pipe #(
        .N_CACHE_BANKS   (16),
        .DATA_WIDTH      (32),
        .UID_WIDTH       (8),
        .UID             (1),
        .MAX_OUTSTANDING (4),
        .RESP_REG        (1)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .request_i     (request_i),
        .destination_i (destination_i),
        .grant_o       (grant_o),
        .request_o     (request_o),
        .grant_i       (grant_i),
        .UID_o         (uid_o),
        .response_i    (response_i),
        .read_data_i   (read_data_i),
        .response_o    (response_o),
        .read_data_o   (read_data_o),
        .outstanding_o (outstanding_o),
        .stray_resp_o  (stray_resp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        request_i     = 1'b0;
        destination_i = '0;
        grant_i       = '0;
        response_i    = '0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        read_data_i = '0;
        step();
        step();
        checks++; if (response_o !== 1'b0) begin failures++; $display("FAIL reset_resp: got %b expected 0", response_o); end
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", outstanding_o); end
        checks++; if (read_data_o !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", read_data_o); end
        checks++; if ({stray_resp_o, grant_o, request_o} !== 18'h0) begin failures++; $display("FAIL reset_misc: got %h expected 0", {stray_resp_o, grant_o, request_o}); end
        checks++; if (uid_o !== 8'd1) begin failures++; $display("FAIL uid: got %h expected 01", uid_o); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_single();
        request_i = 1'b1; destination_i = 4'd5; grant_i = 16'h0020;
        #1;
        checks++; if (request_o !== 16'h0020) begin failures++; $display("FAIL single_req: got %h expected 0020", request_o); end
        checks++; if (grant_o !== 1'b1) begin failures++; $display("FAIL single_gnt: got %b expected 1", grant_o); end
        step();
        idle_inputs();
        checks++; if (outstanding_o !== 3'd1) begin failures++; $display("FAIL single_cnt: got %0d expected 1", outstanding_o); end
        response_i = 16'h0020; read_data_i[5] = 32'hDEADBEEF;
        #1;
        checks++; if (response_o !== 1'b0) begin failures++; $display("FAIL single_early: got %b expected 0", response_o); end
        step();
        response_i = '0;
        checks++; if (response_o !== 1'b1 || read_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL single_resp: got %b/%h expected 1/deadbeef", response_o, read_data_o); end
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL single_cnt0: got %0d expected 0", outstanding_o); end
        step();
        checks++; if (response_o !== 1'b0 || read_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL single_hold: got %b/%h expected 0/deadbeef", response_o, read_data_o); end
    endtask

    task automatic test_full();
        int order [4];
        order = '{2, 3, 4, 6};
        for (int i = 1; i <= 4; i++) begin
            request_i = 1'b1; destination_i = 4'(i); grant_i = 16'(1 << i);
            #1;
            checks++; if (grant_o !== 1'b1) begin failures++; $display("FAIL full_fill%0d: got %b expected 1", i, grant_o); end
            step();
        end
        checks++; if (outstanding_o !== 3'd4) begin failures++; $display("FAIL full_cnt: got %0d expected 4", outstanding_o); end
        destination_i = 4'd6; grant_i = 16'h0040;
        #1;
        checks++; if (grant_o !== 1'b0 || request_o !== 16'h0) begin failures++; $display("FAIL full_block: got %b/%h expected 0/0000", grant_o, request_o); end
        response_i = 16'h0002; read_data_i[1] = 32'hA0000001;
        #1;
        checks++; if (grant_o !== 1'b0) begin failures++; $display("FAIL full_nobypass: got %b expected 0", grant_o); end
        step();
        response_i = '0;
        #1;
        checks++; if (outstanding_o !== 3'd3 || response_o !== 1'b1 || read_data_o !== 32'hA0000001) begin failures++; $display("FAIL full_pop: got %0d/%b/%h expected 3/1/a0000001", outstanding_o, response_o, read_data_o); end
        checks++; if (grant_o !== 1'b1 || request_o !== 16'h0040) begin failures++; $display("FAIL full_regrant: got %b/%h expected 1/0040", grant_o, request_o); end
        step();
        idle_inputs();
        checks++; if (outstanding_o !== 3'd4) begin failures++; $display("FAIL full_refill: got %0d expected 4", outstanding_o); end
        for (int k = 0; k < 4; k++) begin
            response_i = 16'(1 << order[k]);
            read_data_i[order[k]] = 32'hA0000000 + 32'(order[k]);
            step();
            response_i = '0;
            checks++; if (response_o !== 1'b1 || read_data_o !== 32'hA0000000 + 32'(order[k])) begin failures++; $display("FAIL full_drain%0d: got %b/%h expected 1/%h", k, response_o, read_data_o, 32'hA0000000 + 32'(order[k])); end
        end
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL full_empty: got %0d expected 0", outstanding_o); end
        step();
    endtask

    task automatic test_stray();
        request_i = 1'b1; destination_i = 4'd2; grant_i = 16'h0004;
        step();
        destination_i = 4'd7; grant_i = 16'h0080;
        step();
        idle_inputs();
        response_i = 16'h0080; read_data_i[7] = 32'h77777777; read_data_i[2] = 32'h22222222;
        step();
        response_i = '0;
        checks++; if (stray_resp_o !== 1'b1 || response_o !== 1'b0) begin failures++; $display("FAIL stray_pulse: got %b/%b expected 1/0", stray_resp_o, response_o); end
        checks++; if (outstanding_o !== 3'd2) begin failures++; $display("FAIL stray_nopop: got %0d expected 2", outstanding_o); end
        step();
        checks++; if (stray_resp_o !== 1'b0) begin failures++; $display("FAIL stray_clear: got %b expected 0", stray_resp_o); end
        response_i = 16'h0004;
        step();
        response_i = 16'h0080;
        checks++; if (response_o !== 1'b1 || read_data_o !== 32'h22222222) begin failures++; $display("FAIL stray_first: got %b/%h expected 1/22222222", response_o, read_data_o); end
        step();
        response_i = '0;
        checks++; if (response_o !== 1'b1 || read_data_o !== 32'h77777777 || stray_resp_o !== 1'b0) begin failures++; $display("FAIL stray_second: got %b/%h/%b expected 1/77777777/0", response_o, read_data_o, stray_resp_o); end
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL stray_empty: got %0d expected 0", outstanding_o); end
        step();
    endtask

    task automatic test_back_to_back();
        int q[$];
        int head;
        int d;
        logic [31:0] exp_data;
        q = {};
        for (int i = 0; i < 2; i++) begin
            request_i = 1'b1; destination_i = 4'(8 + i); grant_i = 16'(1 << (8 + i));
            step();
            q.push_back(8 + i);
        end
        for (int k = 0; k < 12; k++) begin
            head = q[0];
            d = (10 + k) % 16;
            exp_data = 32'hC0000000 + 32'(k);
            request_i = 1'b1; destination_i = 4'(d); grant_i = 16'(1 << d);
            response_i = 16'(1 << head);
            read_data_i[head] = exp_data;
            #1;
            checks++; if (grant_o !== 1'b1) begin failures++; $display("FAIL b2b_gnt%0d: got %b expected 1", k, grant_o); end
            step();
            checks++; if (response_o !== 1'b1 || read_data_o !== exp_data || outstanding_o !== 3'd2) begin failures++; $display("FAIL b2b_%0d: got %b/%h/%0d expected 1/%h/2", k, response_o, read_data_o, outstanding_o, exp_data); end
            void'(q.pop_front());
            q.push_back(d);
        end
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            head = q.pop_front();
            response_i = 16'(1 << head);
            read_data_i[head] = 32'hD0000000 + 32'(k);
            step();
            response_i = '0;
            checks++; if (response_o !== 1'b1 || read_data_o !== 32'hD0000000 + 32'(k)) begin failures++; $display("FAIL b2b_drain%0d: got %b/%h expected 1/%h", k, response_o, read_data_o, 32'hD0000000 + 32'(k)); end
        end
        checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL b2b_empty: got %0d expected 0", outstanding_o); end
        step();
    endtask

    task automatic test_reset_mid();
        for (int i = 3; i <= 6; i++) begin
            request_i = 1'b1; destination_i = 4'(i); grant_i = 16'(1 << i);
            step();
        end
        idle_inputs();
        response_i = 16'h0008; read_data_i[3] = 32'h33333333; read_data_i[4] = 32'h44444444;
        step();
        response_i = '0;
        checks++; if (outstanding_o !== 3'd3 || response_o !== 1'b1) begin failures++; $display("FAIL mid_pre: got %0d/%b expected 3/1", outstanding_o, response_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (outstanding_o !== 3'd0 || response_o !== 1'b0 || read_data_o !== 32'h0) begin failures++; $display("FAIL mid_async: got %0d/%b/%h expected 0/0/0", outstanding_o, response_o, read_data_o); end
        step();
        rst_ni = 1'b1;
        response_i = 16'h0010;
        step();
        response_i = '0;
        checks++; if (stray_resp_o !== 1'b1 || response_o !== 1'b0 || outstanding_o !== 3'd0) begin failures++; $display("FAIL mid_stray: got %b/%b/%0d expected 1/0/0", stray_resp_o, response_o, outstanding_o); end
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_full();
        test_stray();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
